// File: rtl/dcache_l1_arbiter.sv
// dcache_l1_arbiter
// Shares the single L1 data-cache request port. After rst_i, the per-set
// reset stream is forwarded first. Once that stream ends, L2 refill replies,
// stores and loads are arbitrated onto the port through a 1-entry registered
// output stage.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   rst_valid_i, rst_idx_i        set-reset stream (no back-pressure)
//   l2_valid_i/ready_o/data_i     L2 refill reply requester
//   st_valid_i/ready_o/data_i     store requester
//   ld_valid_i/ready_o/data_i     load requester
//   l1dc_valid_o/ready_i          L1 request handshake
//   l1dc_kind_o, l1dc_data_o      00 reset, 01 L2, 10 store, 11 load; payload
//   init_done_o                   initialisation complete
//   init_err_o                    sticky: reset stream seen after init
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_WAIT | after rst_i, waiting for the first set-reset request
// ST_INIT | forwarding the set-reset stream, no requester grants
// ST_RUN  | init done, L2 / store / load arbitration
module dcache_l1_arbiter #(
   parameter int IDX_LEN       = 8,
   parameter int REQ_W         = 128,
   parameter int MAX_L2_STREAK = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               rst_valid_i,
   input  logic [IDX_LEN-1:0] rst_idx_i,
   input  logic               l2_valid_i,
   output logic               l2_ready_o,
   input  logic [REQ_W-1:0]   l2_data_i,
   input  logic               st_valid_i,
   output logic               st_ready_o,
   input  logic [REQ_W-1:0]   st_data_i,
   input  logic               ld_valid_i,
   output logic               ld_ready_o,
   input  logic [REQ_W-1:0]   ld_data_i,
   output logic               l1dc_valid_o,
   input  logic               l1dc_ready_i,
   output logic [1:0]         l1dc_kind_o,
   output logic [REQ_W-1:0]   l1dc_data_o,
   output logic               init_done_o,
   output logic               init_err_o
);

   typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_RUN} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_L2_STREAK);

   state_t     state;
   logic       rr_ld;      // 0: store wins a st/ld tie, 1: load wins
   logic [3:0] streak;     // consecutive L2 grants while st/ld is pending

   logic can_load;
   logic run;
   logic sl_pend;
   logic l2_capped;
   logic l2_gnt;
   logic st_gnt;
   logic ld_gnt;

   assign can_load  = !l1dc_valid_o || l1dc_ready_i;
   assign run       = (state == ST_RUN);
   assign sl_pend   = st_valid_i || ld_valid_i;
   // L2 yields once it has used its streak budget and someone else waits.
   assign l2_capped = (streak == STREAK_MAX) && sl_pend;
   assign l2_gnt    = run && can_load && l2_valid_i && !l2_capped;
   assign st_gnt    = run && can_load && !l2_gnt && st_valid_i && (!ld_valid_i || !rr_ld);
   assign ld_gnt    = run && can_load && !l2_gnt && ld_valid_i && (!st_valid_i || rr_ld);

   assign l2_ready_o = l2_gnt;
   assign st_ready_o = st_gnt;
   assign ld_ready_o = ld_gnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= ST_WAIT;
         l1dc_valid_o <= 1'b0;
         l1dc_kind_o  <= 2'b00;
         l1dc_data_o  <= '0;
         init_done_o  <= 1'b0;
         init_err_o   <= 1'b0;
         rr_ld        <= 1'b0;
         streak       <= 4'd0;
      end else begin
         case (state)
            ST_WAIT, ST_INIT: begin
               // The reset stream cannot stall, so its entries live for
               // exactly one cycle regardless of l1dc_ready_i.
               if (rst_valid_i) begin
                  l1dc_valid_o <= 1'b1;
                  l1dc_kind_o  <= 2'b00;
                  l1dc_data_o  <= REQ_W'(rst_idx_i);
                  state        <= ST_INIT;
               end else begin
                  l1dc_valid_o <= 1'b0;
                  if (state == ST_INIT) begin
                     state       <= ST_RUN;
                     init_done_o <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (rst_valid_i)
                  init_err_o <= 1'b1;

               if (l2_gnt) begin
                  l1dc_valid_o <= 1'b1;
                  l1dc_kind_o  <= 2'b01;
                  l1dc_data_o  <= l2_data_i;
               end else if (st_gnt) begin
                  l1dc_valid_o <= 1'b1;
                  l1dc_kind_o  <= 2'b10;
                  l1dc_data_o  <= st_data_i;
               end else if (ld_gnt) begin
                  l1dc_valid_o <= 1'b1;
                  l1dc_kind_o  <= 2'b11;
                  l1dc_data_o  <= ld_data_i;
               end else if (l1dc_ready_i) begin
                  l1dc_valid_o <= 1'b0;
               end

               if (st_gnt || ld_gnt)
                  rr_ld <= st_gnt;

               if (st_gnt || ld_gnt || !sl_pend)
                  streak <= 4'd0;
               else if (l2_gnt && (streak != STREAK_MAX))
                  streak <= streak + 4'd1;
            end
            default: state <= ST_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_l1_arbiter.sv
// Directed-vector bench for dcache_l1_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_dcache_l1_arbiter;

   localparam int IDX_LEN = 8;
   localparam int REQ_W   = 128;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               rst_valid_i;
   logic [IDX_LEN-1:0] rst_idx_i;
   logic               l2_valid_i, st_valid_i, ld_valid_i;
   logic               l2_ready_o, st_ready_o, ld_ready_o;
   logic [REQ_W-1:0]   l2_data_i, st_data_i, ld_data_i;
   logic               l1dc_valid_o, l1dc_ready_i;
   logic [1:0]         l1dc_kind_o;
   logic [REQ_W-1:0]   l1dc_data_o;
   logic               init_done_o, init_err_o;

   localparam logic [REQ_W-1:0] D_L2 = 128'hA2A2_0000_0000_0000_0000_0000_0000_1111;
   localparam logic [REQ_W-1:0] D_ST = 128'h5757_0000_0000_0000_0000_0000_0000_2222;
   localparam logic [REQ_W-1:0] D_LD = 128'h1D1D_0000_0000_0000_0000_0000_0000_3333;

   int errors = 0;
   int checks = 0;

   logic [2:0]       rdy;
   logic [130:0]     out_vec;
   logic [130:0]     exp_out;

   assign rdy     = {l2_ready_o, st_ready_o, ld_ready_o};
   assign out_vec = {l1dc_valid_o, l1dc_kind_o, l1dc_data_o};

   dcache_l1_arbiter #(.IDX_LEN(IDX_LEN), .REQ_W(REQ_W), .MAX_L2_STREAK(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rst_valid_i  (rst_valid_i),
      .rst_idx_i    (rst_idx_i),
      .l2_valid_i   (l2_valid_i),
      .l2_ready_o   (l2_ready_o),
      .l2_data_i    (l2_data_i),
      .st_valid_i   (st_valid_i),
      .st_ready_o   (st_ready_o),
      .st_data_i    (st_data_i),
      .ld_valid_i   (ld_valid_i),
      .ld_ready_o   (ld_ready_o),
      .ld_data_i    (ld_data_i),
      .l1dc_valid_o (l1dc_valid_o),
      .l1dc_ready_i (l1dc_ready_i),
      .l1dc_kind_o  (l1dc_kind_o),
      .l1dc_data_o  (l1dc_data_o),
      .init_done_o  (init_done_o),
      .init_err_o   (init_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Output entry when nothing is valid: only the valid bit is meaningful.
   function automatic logic [130:0] out_cmp(input logic [130:0] v, input logic [130:0] e);
      return e[130] ? v : {v[130], 130'd0};
   endfunction

   // One arbitration cycle with l1dc_ready_i=1: check grants against exp_rdy,
   // check the output entry from the previous grant, then predict the next.
   task automatic run_cycle(input string tag, input logic [2:0] exp_rdy);
      @(negedge clk_i);
      check({tag, "_rdy"}, {128'd0, rdy}, {128'd0, exp_rdy});
      check({tag, "_out"}, out_cmp(out_vec, exp_out), exp_out);
      case (exp_rdy)
         3'b100:  exp_out = {1'b1, 2'b01, D_L2};
         3'b010:  exp_out = {1'b1, 2'b10, D_ST};
         3'b001:  exp_out = {1'b1, 2'b11, D_LD};
         default: exp_out = '0;
      endcase
      step();
   endtask

   task automatic idle_reqs();
      l2_valid_i = 1'b0;
      st_valid_i = 1'b0;
      ld_valid_i = 1'b0;
   endtask

   // Reset, stream n set indices, then land in ST_RUN with an empty output.
   task automatic do_init(input int n);
      rst_i = 1'b1;
      rst_valid_i = 1'b0;
      idle_reqs();
      l1dc_ready_i = 1'b1;
      step();
      rst_i = 1'b0;
      step();
      for (int i = 0; i < n; i++) begin
         rst_valid_i = 1'b1;
         rst_idx_i   = IDX_LEN'(i);
         step();
      end
      rst_valid_i = 1'b0;
      step();
      @(negedge clk_i);
      check("init_done_run", {130'd0, init_done_o}, 131'd1);
      step();
      exp_out = '0;
   endtask

   initial begin
      rst_i = 1'b1;
      rst_valid_i = 1'b0;
      rst_idx_i = '0;
      l2_valid_i = 1'b1;
      st_valid_i = 1'b1;
      ld_valid_i = 1'b1;
      l2_data_i = D_L2;
      st_data_i = D_ST;
      ld_data_i = D_LD;
      l1dc_ready_i = 1'b0;
      exp_out = '0;

      // Reset state
      @(negedge clk_i);
      check("rst_out", out_vec, 131'd0);
      check("rst_rdy", {128'd0, rdy}, 131'd0);
      check("rst_flags", {129'd0, init_done_o, init_err_o}, 131'd0);
      step();
      rst_i = 1'b0;

      // Idle in ST_WAIT with all requesters valid
      @(negedge clk_i);
      check("wait_rdy", {128'd0, rdy}, 131'd0);
      step();

      // Reset stream 0..255 with L1 back-pressure, requesters valid throughout
      for (int i = 0; i < 256; i++) begin
         rst_valid_i = 1'b1;
         rst_idx_i   = IDX_LEN'(i);
         @(negedge clk_i);
         check("init_rdy", {128'd0, rdy}, 131'd0);
         if (i == 0)
            check("init_out0", {130'd0, l1dc_valid_o}, 131'd0);
         else
            check("init_out", out_vec, {1'b1, 2'b00, 128'(i - 1)});
         step();
      end
      rst_valid_i = 1'b0;
      @(negedge clk_i);
      check("init_last", out_vec, {1'b1, 2'b00, 128'd255});
      check("init_rdy_end", {128'd0, rdy}, 131'd0);
      check("init_done_lo", {130'd0, init_done_o}, 131'd0);
      step();
      idle_reqs();
      @(negedge clk_i);
      check("init_done_hi", {130'd0, init_done_o}, 131'd1);
      check("init_clr", {130'd0, l1dc_valid_o}, 131'd0);
      step();

      // Back-pressure: one load grant, entry held while l1dc_ready_i=0
      ld_valid_i = 1'b1;
      l1dc_ready_i = 1'b0;
      @(negedge clk_i);
      check("bp_grant", {128'd0, rdy}, 131'd1);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("bp_hold_rdy", {128'd0, rdy}, 131'd0);
         check("bp_hold_out", out_vec, {1'b1, 2'b11, D_LD});
         step();
      end
      ld_valid_i = 1'b0;
      l1dc_ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_release", out_vec, {1'b1, 2'b11, D_LD});
      step();
      @(negedge clk_i);
      check("bp_done", {130'd0, l1dc_valid_o}, 131'd0);
      step();

      // Round-robin store/load, starting with store after reset
      do_init(2);
      st_valid_i = 1'b1;
      ld_valid_i = 1'b1;
      for (int k = 0; k < 8; k++)
         run_cycle("rr", (k % 2 == 0) ? 3'b010 : 3'b001);
      idle_reqs();
      run_cycle("rr_tail", 3'b000);

      // Anti-starvation: 4 L2 then st, 4 L2 then ld
      do_init(2);
      l2_valid_i = 1'b1;
      st_valid_i = 1'b1;
      ld_valid_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         int p;
         p = k % 10;
         run_cycle("starve", (p == 4) ? 3'b010 : (p == 9) ? 3'b001 : 3'b100);
      end
      idle_reqs();
      run_cycle("starve_tail", 3'b000);

      // Streak reset when store drops for one cycle
      do_init(1);
      l2_valid_i = 1'b1;
      st_valid_i = 1'b1;
      for (int k = 0; k < 3; k++)
         run_cycle("streak_a", 3'b100);
      st_valid_i = 1'b0;
      run_cycle("streak_gap", 3'b100);
      st_valid_i = 1'b1;
      for (int k = 0; k < 4; k++)
         run_cycle("streak_b", 3'b100);
      run_cycle("streak_st", 3'b010);
      idle_reqs();

      // Reset request after init: not forwarded, sticky error
      rst_valid_i = 1'b1;
      rst_idx_i   = 8'h5A;
      run_cycle("err_pulse", 3'b000);
      rst_valid_i = 1'b0;
      run_cycle("err_nofwd", 3'b000);
      @(negedge clk_i);
      check("err_set", {130'd0, init_err_o}, 131'd1);
      step();
      run_cycle("err_idle", 3'b000);
      run_cycle("err_idle", 3'b000);
      @(negedge clk_i);
      check("err_sticky", {130'd0, init_err_o}, 131'd1);
      step();

      // Async reset with an entry held
      ld_valid_i = 1'b1;
      l1dc_ready_i = 1'b0;
      @(negedge clk_i);
      check("ar_grant", {128'd0, rdy}, 131'd1);
      step();
      ld_valid_i = 1'b0;
      @(negedge clk_i);
      check("ar_held", out_vec, {1'b1, 2'b11, D_LD});
      #2;
      rst_i = 1'b1;
      #1;
      check("ar_out", {130'd0, l1dc_valid_o}, 131'd0);
      check("ar_flags", {129'd0, init_done_o, init_err_o}, 131'd0);
      step();
      rst_i = 1'b0;
      l2_valid_i = 1'b1;
      st_valid_i = 1'b1;
      ld_valid_i = 1'b1;
      l1dc_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check("ar_wait_rdy", {128'd0, rdy}, 131'd0);
         check("ar_wait_done", {130'd0, init_done_o}, 131'd0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_l1_arbiter.md
Name: dcache_l1_arbiter

Overview:
- Single-port sharer for the L1 data-cache request port.
- Sequences the start-up cache initialisation: the per-set reset stream is forwarded first, and no other traffic is granted until initialisation completes.
- After initialisation it arbitrates between three requesters:
  - L2 refill replies (priority with anti-starvation);
  - store requests and load requests (round-robin between the two).
- Drives the L1 port through a 1-entry registered output stage.

Parameters:
- IDX_LEN, DCACHE_L1_IDX_A_LEN, width of the reset set-index stream.
- REQ_W, 128, payload width of L2/store/load requests.
- MAX_L2_STREAK, 4, maximum consecutive L2 grants while a store/load is pending; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- rst_valid_i  in  1  set-reset request valid. The source has no ready and advances every cycle.
- rst_idx_i  in  IDX_LEN  set index to clear.
- l2_valid_i  in  1  L2 refill reply valid.
- l2_ready_o  out  1  L2 reply accepted (grant).
- l2_data_i  in  REQ_W  L2 reply payload.
- st_valid_i  in  1  store request valid.
- st_ready_o  out  1  store grant.
- st_data_i  in  REQ_W  store payload.
- ld_valid_i  in  1  load request valid.
- ld_ready_o  out  1  load grant.
- ld_data_i  in  REQ_W  load payload.
- l1dc_valid_o  out  1  request to L1 valid.
- l1dc_ready_i  in  1  L1 accepts request.
- l1dc_kind_o  out  2  request kind: 00 reset, 01 L2, 10 store, 11 load.
- l1dc_data_o  out  REQ_W  payload. For kind 00, carries rst_idx_i zero-extended.
- init_done_o  out  1  initialisation complete.
- init_err_o  out  1  sticky: rst_valid_i was seen after initialisation.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - state=StWait;
  - output register empty (l1dc_valid_o=0, kind=00, data=0);
  - all *_ready_o=0;
  - init_done_o=0, init_err_o=0;
  - rr pointer=store, streak counter=0.
  - Reset asserted mid-transfer drops the held entry; requesters must re-present.
- FSM:
  - StWait: no grants. Transition to StInit when rst_valid_i=1.
  - StInit: each cycle with rst_valid_i=1, load {kind 00, rst_idx_i} into the output register. l1dc_ready_i is ignored for kind 00: entry is valid for exactly one cycle, then overwritten or cleared. First cycle with rst_valid_i=0 → StRun.
  - StRun: init_done_o=1 (registered, asserted in the first StRun cycle). Normal arbitration.
- init_err_o: rst_valid_i=1 in StRun sets init_err_o. Reset requests in StRun are never forwarded; only rst_i clears the flag.
- Output stage load condition: can_load = !l1dc_valid_o | l1dc_ready_i.
  - Grants occur only when can_load.
  - At most one *_ready_o is high per cycle.
  - ready_o is combinational from valid inputs and state; it never depends on its own valid in a loop.
- Latency: grant in cycle N → l1dc_valid_o in N+1.
  - With l1dc_ready_i held high: full throughput, one request per cycle.
  - With l1dc_ready_i low: entry, kind and data are held stable until accepted.
- Arbitration in StRun, when can_load:
  1. L2 wins if l2_valid_i and not (streak==MAX_L2_STREAK and (st_valid_i|ld_valid_i)).
  2. Otherwise st/ld round-robin:
     - if both valid, grant the one indicated by rr;
     - if only one valid, grant it.
     - rr flips to the other requester after any store or load grant.
- Streak counter:
  - increments on an L2 grant while st_valid_i|ld_valid_i;
  - resets to 0 on any store/load grant, or on any cycle with no store/load pending;
  - saturates at MAX_L2_STREAK.
- Simultaneous events:
  - All three requesters valid with streak<MAX: L2 wins.
  - A valid held without grant must keep its payload stable; the arbiter does not check this.
- No grants in StWait or StInit, even when requesters are valid.

Test Plan:
- Reset sequence: rst_i pulse, then rst_valid_i high for 256 cycles with idx 0..255, l1dc_ready_i=0 → l1dc_valid_o=1, kind 00, data=idx on cycles 1..256 after each input. init_done_o rises 1 cycle after rst_valid_i falls. No *_ready_o asserted throughout, even with st/ld/l2 valid.
- Back-pressure: StRun, ld_valid_i held, l1dc_ready_i=0 for 5 cycles → exactly one ld grant. Output held constant (kind 11, same data) for 5 cycles; single transfer on release.
- Round-robin: st and ld continuously valid, ready=1 → grants alternate st, ld, st, ld…, starting with st after reset.
- Anti-starvation with MAX_L2_STREAK=4: l2, st and ld all continuously valid → pattern of 4 L2 grants then 1 st, 4 L2 then 1 ld, repeating.
- Streak reset: 3 L2 grants with st pending, then st_valid_i drops for 1 cycle → streak returns to 0, and the next 4 grants go to L2.
- Error and async reset: rst_valid_i pulsed in StRun → nothing forwarded, init_err_o=1 sticky. Then rst_i asserted with an entry held (ready=0) → l1dc_valid_o=0 immediately, state StWait, init_err_o=0.
